// File: rtl/mux8lut_cfg_sequencer.sv
// mux8lut_cfg_sequencer
//   Round-robin arbiter and frame-write sequencer for a column of
//   MUX8LUT frame-config slots. Requesters ask for a new 2-bit mode {c1,c0}
//   for one slot. The block keeps a shadow copy of every slot's committed
//   mode. Each accepted change is emitted as a full frame write: the data is
//   set up, FrameStrobe[FrameIdx] is pulsed for StrobeLen cycles, and the
//   data is then held for one more cycle.
//
// Ports
//   CLK          config clock
//   resetn       asynchronous reset, active low
//   req_valid    per-requester request, held until accepted
//   req_slot     per-requester slot index, requester r at [r*SlotW +: SlotW]
//   req_mode     per-requester new {c1,c0}, requester r at [2r +: 2]
//   req_ready    one-hot accept strobe; a transfer happens when valid & ready
//   FrameData    frame word to the tile
//   FrameStrobe  frame strobes to the tile; only bit FrameIdx is ever driven
//   busy         high while a frame write is in flight
//   err_slot     one-cycle pulse after accepting a request with an
//                out-of-range slot
//   shadow_mode  committed mode of every slot, slot i at [2i +: 2]
module mux8lut_cfg_sequencer #(
  parameter int NumReq    = 2,
  parameter int NumSlots  = 4,
  parameter int FrameBits = 32,
  parameter int NumFrames = 20,
  parameter int FrameIdx  = 0,
  parameter int BitBase   = 0,
  parameter int StrobeLen = 2,
  parameter int SlotW     = 2
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic [NumReq-1:0]         req_valid,
  input  logic [NumReq*SlotW-1:0]   req_slot,
  input  logic [NumReq*2-1:0]       req_mode,
  output logic [NumReq-1:0]         req_ready,
  output logic [FrameBits-1:0]      FrameData,
  output logic [NumFrames-1:0]      FrameStrobe,
  output logic                      busy,
  output logic                      err_slot,
  output logic [2*NumSlots-1:0]     shadow_mode
);

  localparam int RrW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = (StrobeLen > 1) ? $clog2(StrobeLen) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [RrW-1:0]       rr_q, rr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*NumSlots-1:0] shadow_q, shadow_d;
  logic [FrameBits-1:0] frame_q, frame_d;
  logic                 err_q, err_d;

  // Round-robin search: first valid requester strictly after the pointer.
  logic           grant_found;
  logic [RrW-1:0] grant_idx;
  logic [RrW-1:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = RrW'((int'(rr_q) + k) % NumReq);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Acceptance is only possible in IDLE. Gating with resetn keeps req_ready
  // low for the whole reset, not only after the state register clears.
  logic accept;
  assign accept = resetn && (state_q == S_IDLE) && grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == RrW'(gi));
    end
  endgenerate

  logic [SlotW-1:0] sel_slot;
  logic [1:0]       sel_mode;
  logic             slot_ok;
  int               slot_idx;
  logic [1:0]       cur_mode;

  always_comb begin
    sel_slot = req_slot[int'(grant_idx)*SlotW +: SlotW];
    sel_mode = req_mode[int'(grant_idx)*2 +: 2];
    slot_ok  = int'(sel_slot) < NumSlots;
    // Keep the shadow index in range even when the request is bad.
    slot_idx = slot_ok ? int'(sel_slot) : 0;
    cur_mode = shadow_q[2*slot_idx +: 2];
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        frame_d = '0;
        if (accept) begin
          rr_d = grant_idx;
          if (!slot_ok) begin
            err_d = 1'b1;
          end else if (sel_mode != cur_mode) begin
            // Commit now; the frame word carries the updated shadow.
            shadow_d[2*slot_idx +: 2] = sel_mode;
            frame_d[BitBase +: 2*NumSlots] = shadow_d;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = CntW'(StrobeLen - 1);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rr_q     <= RrW'(NumReq - 1);
      cnt_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  generate
    for (gi = 0; gi < NumFrames; gi++) begin : g_strobe
      if (gi == FrameIdx) begin : g_active
        assign FrameStrobe[gi] = (state_q == S_STROBE);
      end else begin : g_idle
        assign FrameStrobe[gi] = 1'b0;
      end
    end
  endgenerate

  assign FrameData   = frame_q;
  assign busy        = (state_q != S_IDLE);
  assign err_slot    = err_q;
  assign shadow_mode = shadow_q;

endmodule
